// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and limits for the stopwatch controller: FSM state, BCD digit type
// and the per-digit wrap values.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRunning,
    StPaused,
    StLap
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t D0Max = 4'd9;
  localparam bcd_t D1Max = 4'd9;
  localparam bcd_t D2Max = 4'd5;
  localparam bcd_t D3Max = 4'd9;

  // Next value of a single BCD digit that wraps to zero after max.
  function automatic bcd_t bcd_next(bcd_t q, logic en, bcd_t max);
    if (!en) begin
      return q;
    end
    if (q == max) begin
      return '0;
    end
    return q + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, display digits and status flags out, between the debounce stage,
// the stopwatch controller and the seven-segment driver.
interface stopwatch_ctrl_if;

  logic                     start_stop;
  logic                     lap_reset;
  stopwatch_ctrl_pkg::bcd_t digit0;
  stopwatch_ctrl_pkg::bcd_t digit1;
  stopwatch_ctrl_pkg::bcd_t digit2;
  stopwatch_ctrl_pkg::bcd_t digit3;
  logic                     running;
  logic                     lap_active;
  logic                     rollover;

  modport master (
    output start_stop,
    output lap_reset,
    input  digit0,
    input  digit1,
    input  digit2,
    input  digit3,
    input  running,
    input  lap_active,
    input  rollover
  );

  modport slave (
    input  start_stop,
    input  lap_reset,
    output digit0,
    output digit1,
    output digit2,
    output digit3,
    output running,
    output lap_active,
    output rollover
  );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// One BCD digit of the stopwatch timebase: counts 0..Max on en, carry out when wrapping.
module bcd_digit_counter
  import stopwatch_ctrl_pkg::*;
#(
  parameter bcd_t Max = 4'd9
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output bcd_t q,
  output logic carry
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = clr ? '0 : bcd_next(q_q, en, Max);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en && (q_q == Max);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM (idle/run/pause/lap), tenths-of-a-second prescaler,
// 4-digit BCD counter chain, lap latch and registered display outputs.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned ClkHz  = 100_000_000,
  parameter int unsigned TickHz = 10
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  stopwatch_ctrl_if.slave   sw
);

  localparam int unsigned Div    = ClkHz / TickHz;
  localparam int unsigned PrescW = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(Div - 1);
  localparam logic [3:0][3:0]   DigitMax  = {D3Max, D2Max, D1Max, D0Max};

  sw_state_t         state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [3:0][3:0]   lap_q, lap_d;
  logic [3:0][3:0]   disp_q, disp_d;
  logic              running_q, lap_active_q, rollover_q;

  logic              active, tick, clr;
  logic [3:0][3:0]   live, live_nxt;
  logic [3:0]        carry, en;

  assign en = {carry[2:0], tick};

  for (genvar i = 0; i < 4; i++) begin : gen_digit
    bcd_digit_counter #(
      .Max(DigitMax[i])
    ) u_digit (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .clr       (clr),
      .en        (en[i]),
      .q         (live[i]),
      .carry     (carry[i])
    );
  end

  always_comb begin
    active  = (state_q == StRunning) || (state_q == StLap);
    tick    = active && (presc_q == PrescLast);
    state_d = state_q;
    presc_d = presc_q;
    clr     = 1'b0;

    if (active) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // start_stop is checked first everywhere so it wins over a simultaneous lap_reset.
    unique case (state_q)
      StIdle: begin
        if (sw.start_stop) begin
          state_d = StRunning;
          presc_d = '0;
        end
      end
      StRunning: begin
        if (sw.start_stop) begin
          state_d = StPaused;
        end else if (sw.lap_reset) begin
          state_d = StLap;
        end
      end
      StLap: begin
        if (sw.start_stop) begin
          state_d = StPaused;
        end else if (sw.lap_reset) begin
          state_d = StRunning;
        end
      end
      StPaused: begin
        if (sw.start_stop) begin
          state_d = StRunning;
        end else if (sw.lap_reset) begin
          state_d = StIdle;
          clr     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Mirror of the counter chain so the display register lands together with the new digits.
    for (int i = 0; i < 4; i++) begin
      live_nxt[i] = clr ? 4'd0 : bcd_next(live[i], en[i], DigitMax[i]);
    end

    lap_d  = ((state_d == StLap) && (state_q != StLap)) ? live : lap_q;
    disp_d = (state_d == StLap) ? lap_d : live_nxt;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      lap_q        <= '0;
      disp_q       <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      rollover_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      lap_q        <= lap_d;
      disp_q       <= disp_d;
      running_q    <= (state_d == StRunning) || (state_d == StLap);
      lap_active_q <= (state_d == StLap);
      rollover_q   <= carry[3];
    end
  end

  assign sw.digit0     = disp_q[0];
  assign sw.digit1     = disp_q[1];
  assign sw.digit2     = disp_q[2];
  assign sw.digit3     = disp_q[3];
  assign sw.running    = running_q;
  assign sw.lap_active = lap_active_q;
  assign sw.rollover   = rollover_q;

endmodule
